// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver deframing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DEFAULT_OVERSAMPLE = 8;

  // Two-of-three vote used on the mid-bit samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Last value of the free-running oversample tick counter
  function automatic int calc_tick_top(input int clock, input int baud, input int os);
    return clock / (baud * os) - 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of the buffered UART receiver (FWFT valid/read).
// Latency: a pop on rd_en && rd_valid updates rd_data/rd_valid on the next clk.
// Backpressure: consumer paces the FIFO with rd_en; rd_en while empty is ignored.
interface uart_rx_fifo_if;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (output rd_data, output rd_valid, input rd_en);
  modport slave  (input rd_data, input rd_valid, output rd_en);
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with occupancy count.
// Latency: pushed word is visible at the head 1 clk after the push.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot the write lands in, so a full FIFO can still accept.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // Head is forced to zero while empty so the read bus is clean at reset.
  assign o_dat     = o_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents need no reset because the count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit majority sampling feeding an FWFT byte FIFO.
// Latency: byte appears on rd_valid/rd_data 1 clk after the stop-bit decision tick.
// Backpressure: none on the line; a good byte arriving to a full FIFO is dropped and flagged.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK      = 12000000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             rx_pin,
  uart_rx_fifo_if.master   rd_bus,
  output logic [FIFO_AW:0] fifo_count,
  output logic             framing_err,
  output logic             overrun_err,
  input  logic             err_clear,
  output logic             busy
);
  localparam int TICK_TOP = calc_tick_top(CLOCK, BAUDRATE, OVERSAMPLE);
  localparam int TICK_W   = (TICK_TOP > 0) ? $clog2(TICK_TOP + 1) : 1;
  localparam int S_W      = $clog2(OVERSAMPLE);
  localparam int MID      = OVERSAMPLE / 2;
  localparam logic [TICK_W-1:0] TICK_TOP_V = TICK_W'(TICK_TOP);
  localparam logic [S_W-1:0]    S_LO   = S_W'(MID - 1);
  localparam logic [S_W-1:0]    S_MID  = S_W'(MID);
  localparam logic [S_W-1:0]    S_HI   = S_W'(MID + 1);
  localparam logic [S_W-1:0]    S_LAST = S_W'(OVERSAMPLE - 1);

  logic              r_sync1, r_sync2;
  logic              r_prev;
  logic              r_armed;
  logic [TICK_W-1:0] r_tick_cnt;
  rx_state_e         r_state, w_state_nxt;
  logic [S_W-1:0]    r_s, w_s_nxt, w_s_inc;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic [7:0]        r_data, w_data_nxt;
  logic [2:0]        r_smp;
  logic              r_framing, r_overrun;
  logic              w_rx_s, w_tick, w_maj;
  logic              w_push, w_pop, w_set_fe, w_set_oe;
  logic              w_full, w_empty;

  assign w_rx_s  = r_sync2;
  assign w_tick  = (r_tick_cnt == TICK_TOP_V);
  assign w_s_inc = (r_s == S_LAST) ? '0 : r_s + S_W'(1);
  // The stop decision is taken on the third sample's own tick, so use it live there.
  assign w_maj   = maj3(r_smp[0], r_smp[1], (r_s == S_HI) ? w_rx_s : r_smp[2]);
  assign w_pop   = rd_bus.rd_en & rd_bus.rd_valid;

  assign rd_bus.rd_valid = ~w_empty;
  assign framing_err     = r_framing;
  assign overrun_err     = r_overrun;
  assign busy            = (r_state != ST_IDLE);

  // Two-flop synchroniser, tick-rate previous sample, and re-arm after reset
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= rx_pin;
      r_sync2 <= r_sync1;
      if (w_tick) begin
        r_prev <= w_rx_s;
        if (w_rx_s) r_armed <= 1'b1;
      end
    end
  end

  // Free-running oversample tick divider
  always_ff @(posedge clk) begin
    if (!n_reset) r_tick_cnt <= '0;
    else          r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
  end

  // Capture the three mid-bit samples of the current bit
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_smp <= 3'b111;
    end else if (w_tick && r_state != ST_IDLE) begin
      if (r_s == S_LO)  r_smp[0] <= w_rx_s;
      if (r_s == S_MID) r_smp[1] <= w_rx_s;
      if (r_s == S_HI)  r_smp[2] <= w_rx_s;
    end
  end

  // Deframer state register
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_s       <= w_s_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_data    <= w_data_nxt;
    end
  end

  // Deframer next state, data shift and push/error decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_s_nxt       = r_s;
    w_bit_idx_nxt = r_bit_idx;
    w_data_nxt    = r_data;
    w_push        = 1'b0;
    w_set_fe      = 1'b0;
    w_set_oe      = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          w_s_nxt = '0;
          // Only a falling edge starts a frame; a line stuck low stays idle.
          if (r_armed && r_prev && !w_rx_s) begin
            w_state_nxt = ST_START;
            w_s_nxt     = S_W'(1);
          end
        end
        ST_START: begin
          w_s_nxt = w_s_inc;
          if (r_s == S_LAST) begin
            if (w_maj) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt   = ST_DATA;
              w_bit_idx_nxt = '0;
            end
          end
        end
        ST_DATA: begin
          w_s_nxt = w_s_inc;
          if (r_s == S_LAST) begin
            w_data_nxt = {w_maj, r_data[7:1]};
            if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
            else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          w_s_nxt = w_s_inc;
          // Decide early in the stop bit so a back-to-back start edge is not missed.
          if (r_s == S_HI) begin
            w_state_nxt = ST_IDLE;
            if (!w_maj)                w_set_fe = 1'b1;
            else if (!w_full || w_pop) w_push   = 1'b1;
            else                       w_set_oe = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_framing <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_framing <= w_set_fe | (r_framing & ~err_clear);
      r_overrun <= w_set_oe | (r_overrun & ~err_clear);
    end
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .AW    ($clog2(FIFO_DEPTH))
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .i_push  (w_push),
    .i_dat   (r_data),
    .i_pop   (w_pop),
    .o_dat   (rd_bus.rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames in, FIFO drained by a monitor.
// Latency: 32 clk per bit (tick every 4 clk, 8 ticks per bit).
// Backpressure: the monitor pops only while draining is enabled.
module tb_uart_rx_fifo;
  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       rx_pin;
  logic       err_clear;
  logic       rd_en_mon;
  logic       rd_en_main;
  logic [4:0] fifo_count;
  logic       framing_err;
  logic       overrun_err;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit         drain_en = 1'b0;
  bit         glitch_seen;

  uart_rx_fifo_if bus();
  assign bus.rd_en = rd_en_mon | rd_en_main;

  uart_rx_fifo #(
    .CLOCK      (3200000),
    .BAUDRATE   (100000),
    .OVERSAMPLE (8),
    .FIFO_DEPTH (16),
    .FIFO_AW    (4)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rx_pin      (rx_pin),
    .rd_bus      (bus),
    .fifo_count  (fifo_count),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .err_clear   (err_clear),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rd_valid) begin
        done = 1'b1;
        break;
      end
    end
    drain_en = 1'b0;
    chk(name, 32'(done), 32'd1);
  endtask

  // Pop exactly on the stop decision edge: 77 ticks (308 clk) after busy rises.
  task automatic timed_pop();
    bit         seen = 1'b0;
    logic [7:0] e;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    chk("pop_sync_busy", 32'(seen), 32'd1);
    if (seen) begin
      repeat (307) @(negedge clk);
      chk("full_before_pop", 32'(fifo_count), 32'd16);
      e = exp_q.pop_front();
      chk("pop_head", 32'(bus.rd_data), 32'(e));
      rd_en_main = 1'b1;
      @(negedge clk);
      rd_en_main = 1'b0;
      chk("count_pop_push", 32'(fifo_count), 32'd16);
      chk("busy_after_stop", 32'(busy), 32'd0);
      chk("no_overrun_with_pop", 32'(overrun_err), 32'd0);
    end
  endtask

  // Monitor: pops and scores every head byte while draining is enabled
  initial begin
    rd_en_mon = 1'b0;
    forever begin
      @(negedge clk);
      rd_en_mon = 1'b0;
      if (drain_en && n_reset && bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%02h expected none", bus.rd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(mon_exp));
        end
        rd_en_mon = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset    = 1'b0;
    rx_pin     = 1'b1;
    err_clear  = 1'b0;
    rd_en_main = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_framing", 32'(framing_err), 32'd0);
    chk("rst_overrun", 32'(overrun_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    n_reset = 1'b1;
    idle_bits(2);

    // 1: single good frame
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    chk("t1_valid", 32'(bus.rd_valid), 32'd1);
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_framing", 32'(framing_err), 32'd0);
    chk("t1_overrun", 32'(overrun_err), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    drain("t1_drain");
    chk("t1_valid_after", 32'(bus.rd_valid), 32'd0);
    chk("t1_count_after", 32'(fifo_count), 32'd0);

    // 2: one-tick glitch is rejected as a false start
    glitch_seen = 1'b0;
    rx_pin = 1'b0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 3) rx_pin = 1'b1;
      if (busy) glitch_seen = 1'b1;
    end
    chk("t2_glitch_started", 32'(glitch_seen), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_count", 32'(fifo_count), 32'd0);
    chk("t2_framing", 32'(framing_err), 32'd0);

    // 3: bad stop bit, clear, then the same byte framed correctly
    send_byte(8'h3C, 1'b0);
    idle_bits(2);
    chk("t3_framing", 32'(framing_err), 32'd1);
    chk("t3_count", 32'(fifo_count), 32'd0);
    pulse_clear();
    chk("t3_framing_clr", 32'(framing_err), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle_bits(1);
    chk("t3_framing_ok", 32'(framing_err), 32'd0);
    drain("t3_drain");

    // 4: overflow by one, then a push coinciding with a pop while full
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    chk("t4_count_full", 32'(fifo_count), 32'd16);
    chk("t4_overrun", 32'(overrun_err), 32'd1);
    chk("t4_framing", 32'(framing_err), 32'd0);
    pulse_clear();
    chk("t4_overrun_clr", 32'(overrun_err), 32'd0);
    exp_q.push_back(8'h11);
    fork
      send_byte(8'h11, 1'b1);
      timed_pop();
    join
    drain("t4_drain");

    // 5: back-to-back frames with no idle gap
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    chk("t5_count", 32'(fifo_count), 32'd2);
    drain("t5_drain");

    // 6: reset in the middle of a frame with data and a flag pending
    send_byte(8'h77, 1'b1);
    send_byte(8'h12, 1'b0);
    idle_bits(2);
    chk("t6_pre_count", 32'(fifo_count), 32'd1);
    chk("t6_pre_framing", 32'(framing_err), 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (10) @(negedge clk);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("t6_rd_data", 32'(bus.rd_data), 32'd0);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_framing", 32'(framing_err), 32'd0);
    chk("t6_overrun", 32'(overrun_err), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    n_reset = 1'b1;
    idle_bits(5);
    chk("t6_no_false_frame", 32'(busy), 32'd0);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    idle_bits(1);
    drain("t6_drain");
    idle_bits(12);
    chk("t6_count_end", 32'(fifo_count), 32'd0);
    chk("t6_valid_end", 32'(bus.rd_valid), 32'd0);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
